// File: rtl/op_issuer_pkg.sv
// Shared types and constants for the ALU control-unit op issuer.
package op_issuer_pkg;

  localparam int NUM_OPS = 14;
  localparam int OP_W    = 4;
  localparam logic [OP_W-1:0] LAST_OP = 4'(NUM_OPS - 1);

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_ISSUE     = 2'd1;
  localparam state_t S_WAIT_DONE = 2'd2;
  localparam state_t S_WAIT_END  = 2'd3;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_NOSTART = 2'd2,
    ERR_TMO     = 2'd3
  } err_code_t;

  localparam int FLAG_CO = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_V  = 2;
  localparam int FLAG_N  = 3;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= LAST_OP);
  endfunction

  // Codes 14 and 15 decode to an all-zero select.
  function automatic logic [NUM_OPS-1:0] decode_op(input logic [OP_W-1:0] op);
    return op_legal(op) ? (NUM_OPS'(1) << op) : '0;
  endfunction

endpackage

// File: rtl/op_issuer_fifo.sv
// Small opcode FIFO with wrap-bit pointers and a registered full flag.
module op_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = full_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign push_en = push_i & ~full_q;
  assign pop_en  = pop_i & ~empty_o;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
  // Full is computed from the next pointers so the flag itself can be a flop.
  assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/op_issuer.sv
// Issues queued ALU ops to the control unit via sel/begin and tracks End/out completion.
module op_issuer
  import op_issuer_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int TMO    = 255
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  output logic               begin_o,
  output logic [NUM_OPS-1:0] sel_o,
  input  logic               end_i,
  input  logic               out_i,
  input  logic               co_i,
  input  logic               z_i,
  input  logic               v_i,
  input  logic               n_i,
  output logic [3:0]         flags_o,
  output logic               flags_valid,
  output logic               busy,
  output logic               err_valid,
  output logic [1:0]         err_code
);

  localparam logic [7:0] TMO_C = 8'(TMO);

  logic               fifo_full, fifo_empty, pop, can_take;
  logic [OP_W-1:0]    head_op;
  state_t             state_q, state_d;
  logic [NUM_OPS-1:0] sel_q, sel_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [3:0]         flags_q, flags_d;
  logic               flags_valid_q, flags_valid_d;
  logic               err_valid_q, err_valid_d;
  err_code_t          err_code_q, err_code_d;

  op_fifo #(.WIDTH(OP_W), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (in_valid),
    .data_i  (in_op),
    .pop_i   (pop),
    .data_o  (head_op),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready    = ~fifo_full;
  assign begin_o     = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign sel_o       = sel_q;
  assign flags_o     = flags_q;
  assign flags_valid = flags_valid_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;

  // A new op may be taken when idle, or when the previous one has fully ended.
  assign can_take = (state_q == S_IDLE) || ((state_q == S_WAIT_END) && end_i);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    flags_d       = flags_q;
    flags_valid_d = 1'b0;
    err_valid_d   = 1'b0;
    err_code_d    = err_code_q;
    pop           = 1'b0;
    case (state_q)
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (cnt_q == '0) begin
          if (end_i) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_NOSTART;
            sel_d       = '0;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (out_i) begin
          flags_d[FLAG_CO] = co_i;
          flags_d[FLAG_Z]  = z_i;
          flags_d[FLAG_V]  = v_i;
          flags_d[FLAG_N]  = n_i;
          flags_valid_d    = 1'b1;
          state_d          = S_WAIT_END;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO_C) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_TMO;
            sel_d       = '0;
            state_d     = S_IDLE;
          end
        end
      end
      S_WAIT_END: begin
        if (end_i) begin
          sel_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    // Pop overrides the idle fallback above, giving back-to-back issue.
    if (can_take && !fifo_empty) begin
      pop = 1'b1;
      if (op_legal(head_op)) begin
        sel_d   = decode_op(head_op);
        state_d = S_ISSUE;
      end else begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_ILLEGAL;
        sel_d       = '0;
        state_d     = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      flags_q       <= '0;
      flags_valid_q <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      flags_q       <= flags_d;
      flags_valid_q <= flags_valid_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
    end
  end

endmodule

// File: tb/tb_op_issuer.sv
// Directed self-checking bench for op_issuer with a behavioural control-unit model.
module tb_op_issuer;

  localparam int CU_NORMAL  = 0;
  localparam int CU_NOSTART = 1;
  localparam int CU_NOOUT   = 2;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = '0;
  logic        end_i = 1'b1;
  logic        out_i = 1'b0;
  logic        co_i = 1'b0, z_i = 1'b0, v_i = 1'b0, n_i = 1'b0;
  logic        in_ready, begin_o, flags_valid, busy, err_valid;
  logic [13:0] sel_o;
  logic [3:0]  flags_o;
  logic [1:0]  err_code;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  int beginCount = 0;
  int fvCount = 0;
  int endRiseCyc = 0;
  int cuMode = CU_NORMAL;
  int cuCnt = 0;
  logic cuBusy = 1'b0;
  logic cuHold = 1'b0;
  logic [13:0] issuedQ [$];
  int gapQ [$];
  logic [13:0] expIss [5] = '{14'h0080, 14'h0001, 14'h0002, 14'h0004, 14'h0008};

  op_issuer #(.QDEPTH(4), .TMO(255)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .begin_o(begin_o), .sel_o(sel_o), .end_i(end_i), .out_i(out_i),
    .co_i(co_i), .z_i(z_i), .v_i(v_i), .n_i(n_i),
    .flags_o(flags_o), .flags_valid(flags_valid), .busy(busy),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Control unit: drops End on begin, raises out after 3 counted cycles, then End again.
  always @(negedge clk) begin
    if (!rst_b) begin
      end_i = 1'b1; out_i = 1'b0; cuBusy = 1'b0; cuCnt = 0;
    end else if (cuBusy) begin
      if (out_i) begin
        out_i = 1'b0; end_i = 1'b1; cuBusy = 1'b0; endRiseCyc = cyc;
      end else if (cuMode == CU_NORMAL && !cuHold) begin
        cuCnt++;
        if (cuCnt == 3) out_i = 1'b1;
      end
    end else if (begin_o && cuMode != CU_NOSTART) begin
      end_i = 1'b0; cuBusy = 1'b1; cuCnt = 0;
    end
  end

  always @(negedge clk) begin
    if (begin_o) begin
      beginCount++;
      issuedQ.push_back(sel_o);
      gapQ.push_back(cyc - endRiseCyc);
    end
    if (flags_valid) fvCount++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100us want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_op = 4'($urandom_range(0, 15));
      {n_i, v_i, z_i, co_i} = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    nCompared++; if (sel_o !== 14'h0) begin nMismatched++; $display("[TB] FAIL reset_sel: got %h want 0", sel_o); end
    nCompared++; if (begin_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_begin: got %b want 0", begin_o); end
    nCompared++; if (flags_o !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_flags: got %h want 0", flags_o); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    nCompared++; if (err_code !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_err_code: got %0d want 0", err_code); end
    in_valid = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_op();
    int fv0 = fvCount;
    cuMode = CU_NORMAL; cuHold = 1'b0;
    {n_i, v_i, z_i, co_i} = 4'b1010;
    @(negedge clk); in_valid = 1'b1; in_op = 4'd9;
    @(negedge clk); in_valid = 1'b0;
    nCompared++; if (begin_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_no_bypass: got begin %b want 0", begin_o); end
    @(negedge clk);
    nCompared++; if (begin_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_begin_c1: got %b want 1", begin_o); end
    nCompared++; if (sel_o !== 14'h0200) begin nMismatched++; $display("[TB] FAIL single_sel_c1: got %h want 0200", sel_o); end
    @(negedge clk);
    nCompared++; if (begin_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_begin_c2: got %b want 0", begin_o); end
    repeat (3) @(negedge clk);
    nCompared++; if (flags_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_flags_valid: got %b want 1", flags_valid); end
    nCompared++; if (flags_o !== 4'hA) begin nMismatched++; $display("[TB] FAIL single_flags: got %h want A", flags_o); end
    nCompared++; if (sel_o !== 14'h0200) begin nMismatched++; $display("[TB] FAIL single_sel_held: got %h want 0200", sel_o); end
    @(negedge clk);
    nCompared++; if (sel_o !== 14'h0) begin nMismatched++; $display("[TB] FAIL single_sel_cleared: got %h want 0", sel_o); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_idle: got busy %b want 0", busy); end
    nCompared++; if (fvCount - fv0 !== 1) begin nMismatched++; $display("[TB] FAIL single_fv_pulses: got %0d want 1", fvCount - fv0); end
  endtask

  task automatic test_illegal_op();
    int b0 = beginCount;
    {n_i, v_i, z_i, co_i} = 4'b0011;
    @(negedge clk); in_valid = 1'b1; in_op = 4'd15;
    @(negedge clk); in_op = 4'd2;
    @(negedge clk); in_valid = 1'b0;
    nCompared++; if (err_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL illegal_err_valid: got %b want 1", err_valid); end
    nCompared++; if (err_code !== 2'd1) begin nMismatched++; $display("[TB] FAIL illegal_err_code: got %0d want 1", err_code); end
    nCompared++; if (begin_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL illegal_no_begin: got %b want 0", begin_o); end
    @(negedge clk);
    nCompared++; if (begin_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL illegal_next_begin: got %b want 1", begin_o); end
    nCompared++; if (sel_o !== 14'h0004) begin nMismatched++; $display("[TB] FAIL illegal_next_sel: got %h want 0004", sel_o); end
    nCompared++; if (err_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL illegal_err_one_cycle: got %b want 0", err_valid); end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL illegal_done: got busy %b want 0", busy); end
    nCompared++; if (beginCount - b0 !== 1) begin nMismatched++; $display("[TB] FAIL illegal_begin_count: got %0d want 1", beginCount - b0); end
    nCompared++; if (flags_o !== 4'h3) begin nMismatched++; $display("[TB] FAIL illegal_flags: got %h want 3", flags_o); end
  endtask

  task automatic test_no_start();
    cuMode = CU_NOSTART;
    @(negedge clk); in_valid = 1'b1; in_op = 4'd4;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    nCompared++; if (sel_o !== 14'h0010) begin nMismatched++; $display("[TB] FAIL nostart_sel: got %h want 0010", sel_o); end
    repeat (2) @(negedge clk);
    nCompared++; if (err_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL nostart_err_valid: got %b want 1", err_valid); end
    nCompared++; if (err_code !== 2'd2) begin nMismatched++; $display("[TB] FAIL nostart_err_code: got %0d want 2", err_code); end
    nCompared++; if (sel_o !== 14'h0) begin nMismatched++; $display("[TB] FAIL nostart_sel_clear: got %h want 0", sel_o); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL nostart_idle: got busy %b want 0", busy); end
    @(negedge clk);
    nCompared++; if (err_code !== 2'd2) begin nMismatched++; $display("[TB] FAIL nostart_err_hold: got %0d want 2", err_code); end
    nCompared++; if (flags_o !== 4'h3) begin nMismatched++; $display("[TB] FAIL nostart_flags: got %h want 3", flags_o); end
  endtask

  task automatic test_timeout();
    int fv0 = fvCount;
    cuMode = CU_NOOUT;
    {n_i, v_i, z_i, co_i} = 4'b0101;
    @(negedge clk); in_valid = 1'b1; in_op = 4'd11;
    @(negedge clk); in_valid = 1'b0;
    repeat (256) @(negedge clk);
    nCompared++; if (err_valid !== 1'b0 || busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL tmo_early: got err_valid %b busy %b want 0 1", err_valid, busy); end
    @(negedge clk);
    nCompared++; if (err_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL tmo_err_valid: got %b want 1", err_valid); end
    nCompared++; if (err_code !== 2'd3) begin nMismatched++; $display("[TB] FAIL tmo_err_code: got %0d want 3", err_code); end
    nCompared++; if (sel_o !== 14'h0) begin nMismatched++; $display("[TB] FAIL tmo_sel_clear: got %h want 0", sel_o); end
    nCompared++; if (flags_o !== 4'h3) begin nMismatched++; $display("[TB] FAIL tmo_flags: got %h want 3", flags_o); end
    nCompared++; if (fvCount !== fv0) begin nMismatched++; $display("[TB] FAIL tmo_no_fv: got %0d want %0d", fvCount, fv0); end
  endtask

  task automatic test_fifo_full();
    rst_b = 1'b0;
    cuMode = CU_NORMAL; cuHold = 1'b1;
    {n_i, v_i, z_i, co_i} = 4'b1111;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    issuedQ.delete(); gapQ.delete();
    @(negedge clk); in_valid = 1'b1; in_op = 4'd7;
    @(negedge clk); in_op = 4'd0;
    @(negedge clk); in_op = 4'd1;
    @(negedge clk); in_op = 4'd2;
    @(negedge clk); in_op = 4'd3;
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_ready_before: got %b want 1", in_ready); end
    @(negedge clk); in_op = 4'd5;
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_ready_low: got %b want 0", in_ready); end
    repeat (3) @(negedge clk);
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_ready_held: got %b want 0", in_ready); end
    in_valid = 1'b0;
    cuHold = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_drain: got busy %b want 0", busy); end
    nCompared++; if (issuedQ.size() !== 5) begin nMismatched++; $display("[TB] FAIL full_issue_count: got %0d want 5", issuedQ.size()); end
    for (int i = 0; i < 5 && i < issuedQ.size(); i++) begin
      nCompared++; if (issuedQ[i] !== expIss[i]) begin nMismatched++; $display("[TB] FAIL full_order[%0d]: got %h want %h", i, issuedQ[i], expIss[i]); end
    end
    for (int i = 1; i < 5 && i < gapQ.size(); i++) begin
      nCompared++; if (gapQ[i] !== 1) begin nMismatched++; $display("[TB] FAIL full_b2b_gap[%0d]: got %0d want 1", i, gapQ[i]); end
    end
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_ready_after: got %b want 1", in_ready); end
    nCompared++; if (flags_o !== 4'hF) begin nMismatched++; $display("[TB] FAIL full_flags: got %h want F", flags_o); end
  endtask

  task automatic test_reset_mid_op();
    int b0;
    cuMode = CU_NORMAL; cuHold = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_op = 4'd6;
    @(negedge clk); in_op = 4'd10;
    @(negedge clk); in_op = 4'd11;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_busy_before: got %b want 1", busy); end
    rst_b = 1'b0;
    #1;
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_in_ready: got %b want 1", in_ready); end
    nCompared++; if (sel_o !== 14'h0) begin nMismatched++; $display("[TB] FAIL midrst_sel: got %h want 0", sel_o); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    nCompared++; if (flags_o !== 4'h0) begin nMismatched++; $display("[TB] FAIL midrst_flags: got %h want 0", flags_o); end
    nCompared++; if (begin_o !== 1'b0 || err_valid !== 1'b0 || flags_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_pulses: got begin %b err %b fv %b want 0 0 0", begin_o, err_valid, flags_valid); end
    cuHold = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    b0 = beginCount;
    repeat (8) @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_flushed: got busy %b want 0", busy); end
    nCompared++; if (beginCount !== b0) begin nMismatched++; $display("[TB] FAIL midrst_no_issue: got %0d begins want 0", beginCount - b0); end
    in_valid = 1'b1; in_op = 4'd13;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    nCompared++; if (begin_o !== 1'b1 || sel_o !== 14'h2000) begin nMismatched++; $display("[TB] FAIL midrst_new_issue: got begin %b sel %h want 1 2000", begin_o, sel_o); end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_new_done: got busy %b want 0", busy); end
  endtask

  initial begin
    $display("[TB] op_issuer bench start");
    test_reset();
    test_single_op();
    test_illegal_op();
    test_no_start();
    test_timeout();
    test_fifo_full();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
